// File: rtl/func_chk_pkg.sv
// Shared definitions for the function sweep checker: FSM states,
// the reference truth table and the sweep length.
package func_chk_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Reference function f = xy + yz + x'z, indexed by {x,y,z}
    localparam logic [7:0] TRUTH_F1 = 8'hCA;

    // Number of input vectors in one sweep of a 3-input function
    localparam int VEC_N = 8;

endpackage

// File: rtl/func_sweep_checker.sv
// Stimulus driver and response checker for a 3-input combinational block.
// Walks {x,y,z} = 0..7, holds each vector SETTLE cycles, samples f_in once
// per vector against TRUTH and reports mismatch count, first failing vector
// and an overall pass flag.
module func_sweep_checker
    import func_chk_pkg::*;
#(
    parameter logic [VEC_N-1:0] TRUTH  = TRUTH_F1,
    parameter int               SETTLE = 2,
    parameter int               ERR_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             x,
    output logic             y,
    output logic             z,
    input  logic             f_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       first_err_vec,
    output logic             first_err_valid
);

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);
    localparam logic [2:0] LAST_VEC = 3'(VEC_N - 1);

    // Saturating increment for the mismatch counter
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    state_t           r_state;
    state_t           w_next_state;
    logic [2:0]       r_vec;
    logic [3:0]       r_cnt;
    logic [ERR_W-1:0] r_err_cnt;
    logic [2:0]       r_first_err_vec;
    logic             r_first_err_valid;
    logic             r_pass;

    logic             w_start_sweep;
    logic             w_mismatch;
    logic [ERR_W-1:0] w_err_next;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and per-cycle control decisions
    always_comb begin
        w_next_state  = r_state;
        w_start_sweep = 1'b0;
        w_mismatch    = 1'b0;
        w_err_next    = r_err_cnt;
        case (r_state)
            IDLE, DONE: begin
                // start is only honoured outside a sweep
                if (start) begin
                    w_next_state  = DRIVE;
                    w_start_sweep = 1'b1;
                end
            end
            DRIVE: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = SAMPLE;
                end
            end
            SAMPLE: begin
                w_mismatch = (f_in != TRUTH[r_vec]);
                if (w_mismatch) begin
                    w_err_next = sat_inc(r_err_cnt);
                end
                if (r_vec == LAST_VEC) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = DRIVE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Vector, settle counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec             <= 3'd0;
            r_cnt             <= 4'd0;
            r_err_cnt         <= '0;
            r_first_err_vec   <= 3'd0;
            r_first_err_valid <= 1'b0;
            r_pass            <= 1'b0;
        end else if (w_start_sweep) begin
            r_vec             <= 3'd0;
            r_cnt             <= CNT_LOAD;
            r_err_cnt         <= '0;
            r_first_err_vec   <= 3'd0;
            r_first_err_valid <= 1'b0;
            r_pass            <= 1'b0;
        end else begin
            case (r_state)
                DRIVE: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                SAMPLE: begin
                    r_err_cnt <= w_err_next;
                    if (w_mismatch && !r_first_err_valid) begin
                        r_first_err_vec   <= r_vec;
                        r_first_err_valid <= 1'b1;
                    end
                    if (r_vec == LAST_VEC) begin
                        // Verdict includes the mismatch of the final vector
                        r_pass <= (w_err_next == '0);
                    end else begin
                        r_vec <= r_vec + 3'd1;
                        r_cnt <= CNT_LOAD;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // DUT inputs come straight from the vector register: 0 in IDLE,
    // the current vector during a sweep, 3'b111 once DONE
    assign x               = r_vec[2];
    assign y               = r_vec[1];
    assign z               = r_vec[0];
    assign busy            = (r_state == DRIVE) || (r_state == SAMPLE);
    assign done            = (r_state == DONE);
    assign pass            = r_pass;
    assign err_cnt         = r_err_cnt;
    assign first_err_vec   = r_first_err_vec;
    assign first_err_valid = r_first_err_valid;

endmodule

// File: tb/tb_func_sweep_checker.sv
// Directed bench for func_sweep_checker with a behavioural 3-input DUT
// model that can be correct, inverted or stuck at 0.
module tb_func_sweep_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       x, y, z;
    logic       f_in;
    logic       busy, done, pass;
    logic [3:0] err_cnt;
    logic [2:0] first_err_vec;
    logic       first_err_valid;

    logic       start2;
    logic       x2, y2, z2;
    logic       f_in2;
    logic       busy2, done2, pass2;
    logic [1:0] err_cnt2;
    logic [2:0] first_err_vec2;
    logic       first_err_valid2;

    // 0 = correct, 1 = inverted, 2 = stuck at 0
    int mode;
    int checks;
    int errors;

    func_sweep_checker #(.TRUTH(8'hCA), .SETTLE(2), .ERR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x(x), .y(y), .z(z), .f_in(f_in),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_err_vec(first_err_vec), .first_err_valid(first_err_valid)
    );

    func_sweep_checker #(.TRUTH(8'hCA), .SETTLE(2), .ERR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .x(x2), .y(y2), .z(z2), .f_in(f_in2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
        .first_err_vec(first_err_vec2), .first_err_valid(first_err_valid2)
    );

    function automatic logic good_f(input logic a, input logic b, input logic c);
        return (a & b) | (b & c) | (~a & c);
    endfunction

    always_comb begin
        f_in = good_f(x, y, z);
        if (mode == 1) f_in = ~good_f(x, y, z);
        if (mode == 2) f_in = 1'b0;
    end

    // Second instance always sees an inverted block
    assign f_in2 = ~good_f(x2, y2, z2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one edge; returns just after the sampling edge
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done, bounded
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({x, y, z, busy, done, pass, err_cnt, first_err_vec, first_err_valid} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0",
                     {x, y, z, busy, done, pass, err_cnt, first_err_vec, first_err_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_correct();
        int n;
        mode = 0;
        pulse_start();
        n = 0;
        checks++;
        if ({x, y, z} !== 3'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL correct_first got xyz=%0d busy=%b want xyz=0 busy=1", {x, y, z}, busy);
        end
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (!done) begin
                checks++;
                if ({x, y, z} !== 3'(n / 3) || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL correct_step%0d got xyz=%0d busy=%b want xyz=%0d busy=1",
                             n, {x, y, z}, busy, n / 3);
                end
            end
        end
        checks++;
        if (n != 24) begin
            errors++;
            $display("FAIL correct_latency got %0d want 24", n);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1 || err_cnt !== 4'd0 ||
            first_err_valid !== 1'b0 || {x, y, z} !== 3'd7) begin
            errors++;
            $display("FAIL correct_result got done=%b busy=%b pass=%b err=%0d fev=%b xyz=%0d want 1 0 1 0 0 7",
                     done, busy, pass, err_cnt, first_err_valid, {x, y, z});
        end
        // Results must hold without a new start
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            errors++;
            $display("FAIL correct_hold got done=%b pass=%b want 1 1", done, pass);
        end
    endtask

    task automatic test_inverted();
        int n;
        mode = 1;
        pulse_start();
        wait_done(n);
        checks++;
        if (n != 24 || err_cnt !== 4'd8 || first_err_vec !== 3'd0 ||
            first_err_valid !== 1'b1 || pass !== 1'b0) begin
            errors++;
            $display("FAIL inverted got n=%0d err=%0d fvec=%0d fev=%b pass=%b want 24 8 0 1 0",
                     n, err_cnt, first_err_vec, first_err_valid, pass);
        end
    endtask

    task automatic test_restart_after_fail();
        int n;
        mode = 0;
        pulse_start();
        checks++;
        if (err_cnt !== 4'd0 || first_err_valid !== 1'b0 || pass !== 1'b0 ||
            done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_clear got err=%0d fev=%b pass=%b done=%b busy=%b want 0 0 0 0 1",
                     err_cnt, first_err_valid, pass, done, busy);
        end
        wait_done(n);
        checks++;
        if (n != 24 || pass !== 1'b1 || err_cnt !== 4'd0) begin
            errors++;
            $display("FAIL restart_result got n=%0d pass=%b err=%0d want 24 1 0", n, pass, err_cnt);
        end
    endtask

    task automatic test_stuck0();
        int n;
        mode = 2;
        pulse_start();
        wait_done(n);
        checks++;
        if (err_cnt !== 4'd4 || first_err_vec !== 3'd1 || first_err_valid !== 1'b1 || pass !== 1'b0) begin
            errors++;
            $display("FAIL stuck0 got err=%0d fvec=%0d fev=%b pass=%b want 4 1 1 0",
                     err_cnt, first_err_vec, first_err_valid, pass);
        end
    endtask

    task automatic test_saturate_and_ignore_start();
        int n;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            start2 = (n == 5 || n == 15 || n == 22);
        end
        start2 = 1'b0;
        checks++;
        if (n != 24) begin
            errors++;
            $display("FAIL sat_latency got %0d want 24", n);
        end
        checks++;
        if (err_cnt2 !== 2'd3 || pass2 !== 1'b0 || first_err_vec2 !== 3'd0 || first_err_valid2 !== 1'b1) begin
            errors++;
            $display("FAIL sat_result got err=%0d pass=%b fvec=%0d fev=%b want 3 0 0 1",
                     err_cnt2, pass2, first_err_vec2, first_err_valid2);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        mode = 1;
        pulse_start();
        repeat (10) @(posedge clk);
        #3;
        checks++;
        if (busy !== 1'b1 || err_cnt !== 4'd3) begin
            errors++;
            $display("FAIL midsweep_pre got busy=%b err=%0d want 1 3", busy, err_cnt);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({x, y, z, busy, done, pass, err_cnt, first_err_vec, first_err_valid} !== 14'd0) begin
            errors++;
            $display("FAIL midsweep_reset got %b want 0",
                     {x, y, z, busy, done, pass, err_cnt, first_err_vec, first_err_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        mode = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midsweep_idle got busy=%b done=%b want 0 0", busy, done);
        end
        pulse_start();
        wait_done(n);
        checks++;
        if (n != 24 || pass !== 1'b1 || err_cnt !== 4'd0 || first_err_valid !== 1'b0) begin
            errors++;
            $display("FAIL midsweep_resweep got n=%0d pass=%b err=%0d fev=%b want 24 1 0 0",
                     n, pass, err_cnt, first_err_valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mode   = 0;
        start  = 1'b0;
        start2 = 1'b0;
        rst_n  = 1'b1;
        test_reset();
        test_correct();
        test_inverted();
        test_restart_after_fail();
        test_stuck0();
        test_saturate_and_ignore_start();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
